// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program into instruction memory, stalls then resets the pipeline
//
// Optional feature macro: IMEM_BOOT_LOADER_CHECKSUM_EN (trailing checksum word on the stream)
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   start, word_count     - load request and number of words (sampled on start)
//   s_valid/s_data/s_ready- program word stream
//   mem_we/mem_wa/mem_wd  - registered instruction memory write port (byte address)
//   cpu_stall, cpu_reset  - pipeline freeze and pipeline reset request
//   busy, done, error     - status: not idle, load-complete pulse, sticky error
module imem_boot_loader #(
    parameter int DEPTH        = 1024,
    parameter int AW           = $clog2(DEPTH),
    parameter int RESET_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   word_count,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [31:0]   mem_wa,
    output logic [31:0]   mem_wd,
    output logic          cpu_stall,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_CHECK, ST_DRAIN, ST_RELEASE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_DRAIN, ST_RELEASE
    } state_t;
`endif

    localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [7:0]  RST_LAST  = 8'(RESET_CYCLES - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] index_q, index_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    rst_cnt_q, rst_cnt_d;
    logic          s_ready_q, s_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_wa_q, mem_wa_d;
    logic [31:0]   mem_wd_q, mem_wd_d;
    logic          cpu_stall_q, cpu_stall_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          handshake;
    logic          last_word;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0]   sum_q, sum_d;
    // Keeps the pipeline frozen after a checksum mismatch until a new load is accepted.
    logic          stall_hold_q, stall_hold_d;
`endif

    assign handshake = s_valid & s_ready_q;
    assign last_word = ({1'b0, index_q} == (count_q - (AW + 1)'(1)));

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        rst_cnt_d = rst_cnt_q;
        mem_we_d  = 1'b0;
        mem_wa_d  = mem_wa_q;
        mem_wd_d  = mem_wd_q;
        done_d    = 1'b0;
        error_d   = error_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        stall_hold_d = stall_hold_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else if (word_count > DEPTH_W) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        count_d = word_count;
                        index_d = '0;
                        state_d = ST_LOAD;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                        sum_d        = '0;
                        stall_hold_d = 1'b0;
`endif
                    end
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    mem_we_d = 1'b1;
                    mem_wa_d = {{(30 - AW){1'b0}}, index_q, 2'b00};
                    mem_wd_d = s_data;
                    // Wraps to 0 only after the final word of a full-depth load; unused then.
                    index_d  = index_q + AW'(1);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                    sum_d = sum_q + s_data;
                    if (last_word) state_d = ST_CHECK;
`else
                    if (last_word) state_d = ST_DRAIN;
`endif
                end
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                // The checksum word is consumed but never written to memory.
                if (handshake) begin
                    if (s_data == sum_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        error_d      = 1'b1;
                        stall_hold_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
`endif
            ST_DRAIN: begin
                rst_cnt_d = '0;
                state_d   = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        busy_d      = (state_d != ST_IDLE);
        cpu_reset_d = (state_d == ST_RELEASE);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        s_ready_d   = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        cpu_stall_d = (state_d != ST_IDLE) || stall_hold_d;
`else
        s_ready_d   = (state_d == ST_LOAD);
        cpu_stall_d = (state_d != ST_IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            count_q     <= '0;
            rst_cnt_q   <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wa_q    <= '0;
            mem_wd_q    <= '0;
            cpu_stall_q <= 1'b0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            stall_hold_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            count_q     <= count_d;
            rst_cnt_q   <= rst_cnt_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_wa_q    <= mem_wa_d;
            mem_wd_q    <= mem_wd_d;
            cpu_stall_q <= cpu_stall_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            stall_hold_q <= stall_hold_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_wa    = mem_wa_q;
    assign mem_wd    = mem_wd_q;
    assign cpu_stall = cpu_stall_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          mem_we;
    logic [31:0]   mem_wa;
    logic [31:0]   mem_wd;
    logic          cpu_stall;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    logic [31:0] prog [11] = '{
        32'h00A00293, 32'h00000313, 32'h00100393, 32'h00730333,
        32'h00138393, 32'hFFF28293, 32'h00602023, 32'h00002503,
        32'h00A50533, 32'h00000013, 32'hFC000EE3
    };

    imem_boot_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .cpu_stall  (cpu_stall),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_wa);
            wr_data.push_back(mem_wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        word_count = (AW + 1)'(n);
        tick();
        start = 1'b0;
    endtask

    // Runs until done (bounded), counting cpu_reset cycles and any early stall release.
    task automatic wait_done(output int rst_cycles, output int stall_drops, output bit seen);
        rst_cycles  = 0;
        stall_drops = 0;
        seen        = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (cpu_reset) rst_cycles++;
            if (!cpu_stall) stall_drops++;
        end
    endtask

    initial begin
        int  rc;
        int  sd;
        bit  seen;

        reset = 1'b1; start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
        tick(); tick();
        chk("rst_outputs", {s_ready, mem_we, cpu_stall, cpu_reset, busy, done, error}, '0);
        chk("rst_wa", mem_wa, 32'h0);
        chk("rst_wd", mem_wd, 32'h0);
        reset = 1'b0;
        tick();

        // zero-length load
        clear_log();
        do_start(0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        tick();
        chk("zero_done_once", done, 1'b0);
        chk("zero_writes", wr_addr.size(), 0);

        // 11-word back-to-back load
        clear_log();
        do_start(11);
        chk("load_ready", s_ready, 1'b1);
        chk("load_stall", cpu_stall, 1'b1);
        chk("load_busy", busy, 1'b1);
        for (int i = 0; i < 11; i++) begin
            s_valid = 1'b1;
            s_data  = prog[i];
            tick();
        end
        s_valid = 1'b0;
        chk("drain_ready", s_ready, 1'b0);
        chk("drain_last_we", mem_we, 1'b1);
        chk("drain_reset", cpu_reset, 1'b0);
        chk("drain_stall", cpu_stall, 1'b1);
        wait_done(rc, sd, seen);
        chk("load_done_seen", seen, 1'b1);
        chk("load_reset_cycles", rc, 4);
        chk("load_stall_held", sd, 0);
        chk("done_stall_rel", cpu_stall, 1'b0);
        chk("done_reset_rel", cpu_reset, 1'b0);
        chk("done_busy", busy, 1'b0);
        chk("load_nwrites", wr_addr.size(), 11);
        for (int i = 0; i < 11 && i < wr_addr.size(); i++) begin
            chk($sformatf("load_wa%0d", i), wr_addr[i], 32'(i * 4));
            chk($sformatf("load_wd%0d", i), wr_data[i], prog[i]);
        end

        // stalled source: valid 1,0,0,1
        clear_log();
        do_start(2);
        s_valid = 1'b1; s_data = 32'h11111111;
        tick();
        chk("stall_we0", mem_we, 1'b1);
        s_valid = 1'b0;
        tick();
        chk("stall_gap1", mem_we, 1'b0);
        tick();
        chk("stall_gap2", mem_we, 1'b0);
        s_valid = 1'b1; s_data = 32'h22222222;
        tick();
        s_valid = 1'b0;
        chk("stall_we1", mem_we, 1'b1);
        chk("stall_ready_drop", s_ready, 1'b0);
        wait_done(rc, sd, seen);
        chk("stall_done_seen", seen, 1'b1);
        chk("stall_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk("stall_wa0", wr_addr[0], 32'h0);
            chk("stall_wa1", wr_addr[1], 32'h4);
            chk("stall_wd0", wr_data[0], 32'h11111111);
            chk("stall_wd1", wr_data[1], 32'h22222222);
        end

        // overflow then recovery; start while busy is ignored
        clear_log();
        do_start(1025);
        chk("ovf_error", error, 1'b1);
        chk("ovf_busy", busy, 1'b0);
        tick();
        chk("ovf_sticky", error, 1'b1);
        do_start(1);
        chk("ovf_clear", error, 1'b0);
        chk("ovf_busy_again", busy, 1'b1);
        do_start(1025);
        chk("busy_start_err", error, 1'b0);
        chk("busy_start_busy", busy, 1'b1);
        s_valid = 1'b1; s_data = 32'hCAFEF00D;
        tick();
        s_valid = 1'b0;
        wait_done(rc, sd, seen);
        chk("ovf_done_seen", seen, 1'b1);
        chk("ovf_nwrites", wr_addr.size(), 1);

        // full-depth count accepted
        do_start(1024);
        chk("depth_busy", busy, 1'b1);
        chk("depth_error", error, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("depth_abort_busy", busy, 1'b0);

        // reset mid-load after word 3 of 8
        clear_log();
        do_start(8);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = prog[i];
            tick();
        end
        s_data = prog[3];
        reset  = 1'b1;
        tick();
        reset   = 1'b0;
        s_valid = 1'b0;
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_stall", cpu_stall, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", s_ready, 1'b0);
        chk("mid_rst_nwrites", wr_addr.size(), 3);
        tick();
        clear_log();
        do_start(1);
        s_valid = 1'b1; s_data = 32'h0000ABCD;
        tick();
        s_valid = 1'b0;
        wait_done(rc, sd, seen);
        chk("post_rst_done", seen, 1'b1);
        chk("post_rst_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) chk("post_rst_wa", wr_addr[0], 32'h0);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        // checksum match
        clear_log();
        do_start(2);
        s_valid = 1'b1; s_data = 32'h1; tick();
        s_data = 32'h2; tick();
        chk("ck_ready", s_ready, 1'b1);
        s_data = 32'h3; tick();
        s_valid = 1'b0;
        chk("ck_no_write", mem_we, 1'b0);
        wait_done(rc, sd, seen);
        chk("ck_done", seen, 1'b1);
        chk("ck_nwrites", wr_addr.size(), 2);
        // checksum mismatch
        do_start(2);
        s_valid = 1'b1; s_data = 32'h1; tick();
        s_data = 32'h2; tick();
        s_data = 32'h4; tick();
        s_valid = 1'b0;
        chk("ckbad_error", error, 1'b1);
        chk("ckbad_busy", busy, 1'b0);
        chk("ckbad_stall", cpu_stall, 1'b1);
        chk("ckbad_reset", cpu_reset, 1'b0);
        chk("ckbad_done", done, 1'b0);
        tick(); tick();
        chk("ckbad_stall_held", cpu_stall, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
